training_sample_feeder: RTL and testbench

//  Sample source on the data side of the perceptron training controller's ready/start handshake.

---
 rtl/training_sample_feeder.sv | 172 +++++++++++++++++
 tb/tb_training_sample_feeder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/training_sample_feeder.sv
// Training sample source for the perceptron controller: host-loaded sample memory,
// start/nBus handshake, and per-request sample delivery that wraps every epoch.
module training_sample_feeder #(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int MAX_EPOCHS = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrEn,
    input  logic [ADDR_W-1:0]        wrAddr,
    input  logic signed [DATA_W-1:0] wrX1,
    input  logic signed [DATA_W-1:0] wrX2,
    input  logic                     wrT,
    input  logic [ADDR_W:0]          numSamples,
    input  logic                     go,
    input  logic                     readyToGetData,
    input  logic                     doneSignal,
    output logic                     start,
    output logic [32:0]              nBus,
    output logic signed [DATA_W-1:0] x1,
    output logic signed [DATA_W-1:0] x2,
    output logic                     t,
    output logic                     busy,
    output logic [7:0]               epochCount,
    output logic                     epochLimit,
    output logic                     trainDone,
    output logic                     cfgErr
);

    localparam int MEM_W = 2 * DATA_W + 1;
    localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_V    = (ADDR_W + 1)'(1);
    localparam logic [8:0]      MAX_EP_V = 9'(MAX_EPOCHS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_SERVE  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t              state_r;
    logic [ADDR_W:0]     nsamp_r;
    logic [ADDR_W-1:0]   ptr_r;
    logic [MEM_W-1:0]    mem_r [DEPTH];

    logic                cfg_ok_s;
    logic                accept_s;
    logic                serve_s;
    logic                wrap_s;
    logic [7:0]          epoch_inc_s;

    // Saturating epoch increment: the counter parks at its maximum.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return 8'hFF;
        end else begin
            return value + 8'd1;
        end
    endfunction

    // Decode of go acceptance, sample requests and end-of-epoch wrap.
    always_comb begin
        cfg_ok_s    = 1'b0;
        accept_s    = 1'b0;
        serve_s     = 1'b0;
        wrap_s      = 1'b0;
        epoch_inc_s = sat_inc8(epochCount);
        if ((numSamples != {(ADDR_W + 1){1'b0}}) && (numSamples <= DEPTH_V)) begin
            cfg_ok_s = 1'b1;
        end else begin
            cfg_ok_s = 1'b0;
        end
        if ((state_r == ST_IDLE) && go && cfg_ok_s) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if ((state_r == ST_SERVE) && readyToGetData) begin
            serve_s = 1'b1;
            wrap_s  = ({1'b0, ptr_r} == (nsamp_r - ONE_V));
        end else begin
            serve_s = 1'b0;
            wrap_s  = 1'b0;
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            nsamp_r   <= {(ADDR_W + 1){1'b0}};
            start     <= 1'b0;
            busy      <= 1'b0;
            trainDone <= 1'b0;
            cfgErr    <= 1'b0;
            nBus      <= 33'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        nsamp_r <= numSamples;
                        nBus    <= 33'(numSamples);
                        start   <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= ST_START;
                    end else if (go) begin
                        cfgErr  <= 1'b1;
                    end
                end
                ST_START: begin
                    start   <= 1'b0;
                    state_r <= ST_SERVE;
                end
                ST_SERVE: begin
                    if (doneSignal) begin
                        trainDone <= 1'b1;
                        state_r   <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    trainDone <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    start     <= 1'b0;
                    busy      <= 1'b0;
                    trainDone <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Sample pointer, delivered sample registers and epoch bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r      <= {ADDR_W{1'b0}};
            x1         <= {DATA_W{1'b0}};
            x2         <= {DATA_W{1'b0}};
            t          <= 1'b0;
            epochCount <= 8'd0;
            epochLimit <= 1'b0;
        end else if (accept_s) begin
            ptr_r      <= {ADDR_W{1'b0}};
            epochCount <= 8'd0;
            epochLimit <= 1'b0;
        end else if (serve_s) begin
            {x1, x2, t} <= mem_r[ptr_r];
            if (wrap_s) begin
                ptr_r      <= {ADDR_W{1'b0}};
                epochCount <= epoch_inc_s;
                if ({1'b0, epoch_inc_s} >= MAX_EP_V) begin
                    epochLimit <= 1'b1;
                end
            end else begin
                ptr_r <= ptr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
            end
        end
    end

    // Host sample memory; writes are only honoured while idle and it is never cleared.
    always_ff @(posedge clk) begin
        if (wrEn && (state_r == ST_IDLE)) begin
            mem_r[wrAddr] <= {wrX1, wrX2, wrT};
        end
    end

endmodule

// File: tb/tb_training_sample_feeder.sv
// Directed bench for training_sample_feeder: a per-cycle vector table plus
// hand-written sequences for async reset, config errors and epoch limits.
module tb_training_sample_feeder;

    logic               clk = 1'b0;
    logic               rst;
    logic               wrEn;
    logic [3:0]         wrAddr;
    logic signed [15:0] wrX1, wrX2;
    logic               wrT;
    logic [4:0]         numSamples;
    logic               go, ready, done;

    logic               start, busy, t, epochLimit, trainDone, cfgErr;
    logic [32:0]        nBus;
    logic signed [15:0] x1, x2;
    logic [7:0]         epochCount;

    logic               start_b, busy_b, t_b, lim_b, td_b, cfg_b;
    logic [32:0]        nbus_b;
    logic signed [15:0] x1_b, x2_b;
    logic [7:0]         ep_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    training_sample_feeder dut (
        .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrX1(wrX1), .wrX2(wrX2),
        .wrT(wrT), .numSamples(numSamples), .go(go), .readyToGetData(ready),
        .doneSignal(done), .start(start), .nBus(nBus), .x1(x1), .x2(x2), .t(t),
        .busy(busy), .epochCount(epochCount), .epochLimit(epochLimit),
        .trainDone(trainDone), .cfgErr(cfgErr)
    );

    training_sample_feeder #(.MAX_EPOCHS(2)) dut2 (
        .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrX1(wrX1), .wrX2(wrX2),
        .wrT(wrT), .numSamples(numSamples), .go(go), .readyToGetData(ready),
        .doneSignal(done), .start(start_b), .nBus(nbus_b), .x1(x1_b), .x2(x2_b), .t(t_b),
        .busy(busy_b), .epochCount(ep_b), .epochLimit(lim_b),
        .trainDone(td_b), .cfgErr(cfg_b)
    );

    typedef struct {
        logic               go;
        logic [4:0]         n;
        logic               rdy;
        logic               done;
        logic               e_start;
        logic               e_busy;
        logic [32:0]        e_nbus;
        logic signed [15:0] e_x1;
        logic signed [15:0] e_x2;
        logic               e_t;
        logic [7:0]         e_ep;
        logic               e_td;
        logic               e_cfg;
        logic               e_lim2;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(input logic g, input int n, input logic r, input logic d,
                                input logic s, input logic b, input int nb,
                                input int a1, input int a2, input logic at, input int ep,
                                input logic td, input logic cfg, input logic l2);
        vec_t v;
        v.go = g; v.n = 5'(n); v.rdy = r; v.done = d;
        v.e_start = s; v.e_busy = b; v.e_nbus = 33'(nb);
        v.e_x1 = 16'(a1); v.e_x2 = 16'(a2); v.e_t = at; v.e_ep = 8'(ep);
        v.e_td = td; v.e_cfg = cfg; v.e_lim2 = l2;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input int addr, input int a1, input int a2, input logic at);
        wrEn = 1'b1; wrAddr = 4'(addr); wrX1 = 16'(a1); wrX2 = 16'(a2); wrT = at;
        tick();
        wrEn = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wrEn = 1'b0; wrAddr = 4'd0; wrX1 = 16'sd0; wrX2 = 16'sd0; wrT = 1'b0;
        numSamples = 5'd0; go = 1'b0; ready = 1'b0; done = 1'b0;
        #12;
        check("reset_ctrl", {start, busy, trainDone, cfgErr, epochLimit}, 5'b00000);
        check("reset_data", {nBus, x1, x2, t, epochCount}, 66'd0);
        rst = 1'b0;

        write_mem(0, 3, -2, 1'b1);
        write_mem(1, 100, 7, 1'b0);
        write_mem(2, -5, -300, 1'b1);
        write_mem(3, 1234, -1, 1'b0);

        //            go n  r  d   s  b  nb  x1    x2    t   ep td cfg l2
        vecs[0]  = mk(1, 4, 0, 0,  1, 1, 4,  0,    0,    0,  0, 0, 0, 0);
        vecs[1]  = mk(0, 4, 1, 0,  0, 1, 4,  0,    0,    0,  0, 0, 0, 0);
        vecs[2]  = mk(1, 2, 1, 0,  0, 1, 4,  3,    -2,   1,  0, 0, 0, 0);
        vecs[3]  = mk(0, 4, 0, 0,  0, 1, 4,  3,    -2,   1,  0, 0, 0, 0);
        vecs[4]  = mk(0, 4, 1, 0,  0, 1, 4,  100,  7,    0,  0, 0, 0, 0);
        vecs[5]  = mk(0, 4, 1, 0,  0, 1, 4,  -5,   -300, 1,  0, 0, 0, 0);
        vecs[6]  = mk(0, 4, 1, 0,  0, 1, 4,  1234, -1,   0,  1, 0, 0, 0);
        vecs[7]  = mk(0, 4, 1, 0,  0, 1, 4,  3,    -2,   1,  1, 0, 0, 0);
        vecs[8]  = mk(0, 4, 1, 1,  0, 1, 4,  100,  7,    0,  1, 1, 0, 0);
        vecs[9]  = mk(0, 4, 1, 0,  0, 0, 4,  100,  7,    0,  1, 0, 0, 0);
        vecs[10] = mk(1, 3, 0, 0,  1, 1, 3,  100,  7,    0,  0, 0, 0, 0);
        vecs[11] = mk(0, 3, 0, 0,  0, 1, 3,  100,  7,    0,  0, 0, 0, 0);
        vecs[12] = mk(0, 3, 1, 0,  0, 1, 3,  3,    -2,   1,  0, 0, 0, 0);
        vecs[13] = mk(0, 3, 1, 0,  0, 1, 3,  100,  7,    0,  0, 0, 0, 0);
        vecs[14] = mk(0, 3, 1, 0,  0, 1, 3,  -5,   -300, 1,  1, 0, 0, 0);
        vecs[15] = mk(0, 3, 1, 0,  0, 1, 3,  3,    -2,   1,  1, 0, 0, 0);
        vecs[16] = mk(0, 3, 1, 0,  0, 1, 3,  100,  7,    0,  1, 0, 0, 0);
        vecs[17] = mk(0, 3, 1, 0,  0, 1, 3,  -5,   -300, 1,  2, 0, 0, 1);
        vecs[18] = mk(0, 3, 1, 0,  0, 1, 3,  3,    -2,   1,  2, 0, 0, 1);
        vecs[19] = mk(0, 3, 0, 1,  0, 1, 3,  3,    -2,   1,  2, 1, 0, 1);
        vecs[20] = mk(0, 3, 0, 0,  0, 0, 3,  3,    -2,   1,  2, 0, 0, 1);
        vecs[21] = mk(1, 0, 0, 0,  0, 0, 3,  3,    -2,   1,  2, 0, 1, 1);
        vecs[22] = mk(1, 17, 0, 0, 0, 0, 3,  3,    -2,   1,  2, 0, 1, 1);
        vecs[23] = mk(0, 16, 0, 0, 0, 0, 3,  3,    -2,   1,  2, 0, 1, 1);

        for (int i = 0; i < 24; i++) begin
            go = vecs[i].go; numSamples = vecs[i].n; ready = vecs[i].rdy; done = vecs[i].done;
            tick();
            check($sformatf("v%0d_ctrl", i), {start, busy, trainDone, cfgErr, epochLimit, lim_b},
                  {vecs[i].e_start, vecs[i].e_busy, vecs[i].e_td, vecs[i].e_cfg, 1'b0, vecs[i].e_lim2});
            check($sformatf("v%0d_nbus", i), nBus, vecs[i].e_nbus);
            check($sformatf("v%0d_sample", i), {x1, x2, t}, {vecs[i].e_x1, vecs[i].e_x2, vecs[i].e_t});
            check($sformatf("v%0d_epoch", i), {epochCount, ep_b}, {vecs[i].e_ep, vecs[i].e_ep});
        end
        go = 1'b0; ready = 1'b0; done = 1'b0;

        // Async reset in the middle of SERVE, then restart from sample 0.
        numSamples = 5'd4; go = 1'b1; tick();
        go = 1'b0; tick();
        ready = 1'b1; tick(); tick();
        ready = 1'b0;
        check("pre_rst_sample", {x1, x2, t}, {16'sd100, 16'sd7, 1'b0});
        #2 rst = 1'b1;
        #1;
        check("async_rst_ctrl", {start, busy, trainDone, cfgErr, epochLimit}, 5'b00000);
        check("async_rst_data", {nBus, x1, x2, t, epochCount}, 66'd0);
        #1 rst = 1'b0;
        numSamples = 5'd17; go = 1'b1; tick();
        check("cfg17_after_rst", {cfgErr, start, busy}, 3'b100);
        numSamples = 5'd4; tick();
        go = 1'b0;
        check("restart_start", {start, busy, nBus}, {1'b1, 1'b1, 33'd4});
        tick();
        check("start_one_cycle", {start, busy}, 2'b01);
        ready = 1'b1; tick();
        ready = 1'b0;
        check("restart_first", {x1, x2, t}, {16'sd3, -16'sd2, 1'b1});
        done = 1'b1; tick();
        done = 1'b0; tick();
        check("back_idle", {busy, trainDone}, 2'b00);

        // Single-sample epochs: epoch limit, write while busy, saturation.
        numSamples = 5'd1; go = 1'b1; tick();
        go = 1'b0; tick();
        ready = 1'b1; tick();
        check("lim_pulse1", {ep_b, lim_b, epochLimit}, {8'd1, 1'b0, 1'b0});
        wrEn = 1'b1; wrAddr = 4'd0; wrX1 = 16'sd77; wrX2 = 16'sd77; wrT = 1'b0;
        tick();
        wrEn = 1'b0;
        check("lim_pulse2", {ep_b, lim_b, epochLimit}, {8'd2, 1'b1, 1'b0});
        tick();
        check("lim_pulse3", {ep_b, lim_b, epochLimit}, {8'd3, 1'b1, 1'b0});
        check("mem_unchanged", {x1, x2, t}, {16'sd3, -16'sd2, 1'b1});
        for (int k = 0; k < 260; k++) begin
            tick();
        end
        ready = 1'b0;
        check("epoch_saturate", {epochCount, ep_b}, {8'd255, 8'd255});
        check("lim_at_max", {epochLimit, lim_b}, 2'b11);
        done = 1'b1; tick();
        done = 1'b0;
        check("finish_pulse", {trainDone, busy}, 2'b11);
        tick();
        check("final_idle", {trainDone, busy, start}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
